// File: rtl/controlador_bomba.sv
// Pump controller for a 5-sensor tank: debounces the level sensors, decodes the level
// and sequences the pump through fill, hold-off and latched fault.
//
// state   | meaning
// IDLE    | pump off, waiting for a low level (nivel <= 1)
// FILLING | pump on, watching for full level, sensor error or stalled level
// HOLDOFF | pump off for MIN_OFF_CYCLES before a restart is allowed
// FAULT   | pump off, alarm on, waiting for ack with consistent sensors
module controlador_bomba #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_OFF_CYCLES  = 8,
  parameter int FILL_TIMEOUT    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] sensores_in,
  input  logic       ack_in,
  output logic [4:0] sensores_filt_out,
  output logic [2:0] nivel_out,
  output logic       vazio_out,
  output logic       erro_sensor_out,
  output logic       bomba_out,
  output logic       alarme_out,
  output logic [1:0] estado_out
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILLING = 2'd1, HOLDOFF = 2'd2, FAULT = 2'd3} estado_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(FILL_TIMEOUT + 1);
  localparam int OW = $clog2(MIN_OFF_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [TW-1:0] FILL_MAX = TW'(FILL_TIMEOUT);
  localparam logic [OW-1:0] OFF_MAX  = OW'(MIN_OFF_CYCLES);
  localparam logic [OW-1:0] OFF_LAST = OW'(MIN_OFF_CYCLES - 1);

  logic [4:0]    samp_q, cand_q, filt_q, molhado;
  logic [DW-1:0] deb_cnt, deb_next;
  logic [2:0]    nivel_d, nivel_q, nivel_prev_q;
  logic          consistente, vazio_q, erro_q;
  logic [TW-1:0] tmr_fill;
  logic [OW-1:0] tmr_off;
  estado_t       state_q, state_d;
  logic          bomba_q, bomba_d, alarme_q, alarme_d;

  // A run of identical samples only counts while it differs from the accepted pattern.
  always_comb begin
    deb_next = DW'(1);
    if (samp_q == cand_q && deb_cnt != '0) deb_next = deb_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q  <= 5'b11111;
      cand_q  <= 5'b11111;
      filt_q  <= 5'b11111;
      deb_cnt <= '0;
    end else begin
      samp_q <= sensores_in;
      if (samp_q == filt_q) begin
        deb_cnt <= '0;
      end else if (deb_next >= DEB_MAX) begin
        filt_q  <= samp_q;
        deb_cnt <= '0;
      end else begin
        cand_q  <= samp_q;
        deb_cnt <= deb_next;
      end
    end
  end

  // Sensors are active-low; a valid column of water is wet from bit 0 upwards.
  always_comb begin
    molhado = ~filt_q;
    nivel_d = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (molhado[i]) nivel_d = 3'(i);
    end
    consistente = ((molhado & (molhado + 5'd1)) == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nivel_q      <= 3'd0;
      nivel_prev_q <= 3'd0;
      vazio_q      <= 1'b1;
      erro_q       <= 1'b0;
    end else begin
      nivel_q      <= nivel_d;
      nivel_prev_q <= nivel_q;
      vazio_q      <= (filt_q == 5'b11111);
      erro_q       <= ~consistente;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmr_fill <= '0;
      tmr_off  <= '0;
    end else begin
      if (state_q != FILLING || nivel_q > nivel_prev_q) tmr_fill <= '0;
      else if (tmr_fill != FILL_MAX)                     tmr_fill <= tmr_fill + 1'b1;
      if (state_q != HOLDOFF)     tmr_off <= '0;
      else if (tmr_off != OFF_MAX) tmr_off <= tmr_off + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bomba_q  <= 1'b0;
      alarme_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bomba_q  <= bomba_d;
      alarme_q <= alarme_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (erro_q)              state_d = FAULT;
        else if (nivel_q <= 3'd1) state_d = FILLING;
      end
      FILLING: begin
        if (erro_q)                 state_d = FAULT;
        else if (nivel_q == 3'd4)   state_d = HOLDOFF;
        else if (tmr_fill >= FILL_MAX) state_d = FAULT;
      end
      HOLDOFF: begin
        if (erro_q)                 state_d = FAULT;
        else if (tmr_off >= OFF_LAST) state_d = IDLE;
      end
      FAULT: begin
        if (ack_in && !erro_q) state_d = HOLDOFF;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    bomba_d  = (state_d == FILLING);
    alarme_d = (state_d == FAULT);
  end

  assign sensores_filt_out = filt_q;
  assign nivel_out         = nivel_q;
  assign vazio_out         = vazio_q;
  assign erro_sensor_out   = erro_q;
  assign bomba_out         = bomba_q;
  assign alarme_out        = alarme_q;
  assign estado_out        = state_q;

endmodule

// File: tb/tb_controlador_bomba.sv
// Bench for controlador_bomba: table of sensor patterns through a scoreboard queue,
// then hand-written sequences for fill, debounce, fault, timeout and reset.
module tb_controlador_bomba;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sensores_in;
  logic       ack_in;
  logic [4:0] sensores_filt_out;
  logic [2:0] nivel_out;
  logic       vazio_out, erro_sensor_out, bomba_out, alarme_out;
  logic [1:0] estado_out;

  int checks = 0;
  int failures = 0;

  controlador_bomba dut (
    .clk(clk), .rst_n(rst_n), .sensores_in(sensores_in), .ack_in(ack_in),
    .sensores_filt_out(sensores_filt_out), .nivel_out(nivel_out), .vazio_out(vazio_out),
    .erro_sensor_out(erro_sensor_out), .bomba_out(bomba_out), .alarme_out(alarme_out),
    .estado_out(estado_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pat;
    logic [2:0] nivel;
    logic       vazio;
    logic       erro;
  } vec_t;

  vec_t tabela[11];
  vec_t sb_q[$];

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] exp, input int budget, input string name);
    int n = 0;
    while (estado_out != exp && n < budget) begin
      tick();
      n++;
    end
    chk(name, estado_out, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    vec_t e;
    int n;
    tabela[0]  = '{5'b11111, 3'd0, 1'b1, 1'b0};
    tabela[1]  = '{5'b11110, 3'd0, 1'b0, 1'b0};
    tabela[2]  = '{5'b11100, 3'd1, 1'b0, 1'b0};
    tabela[3]  = '{5'b11000, 3'd2, 1'b0, 1'b0};
    tabela[4]  = '{5'b10000, 3'd3, 1'b0, 1'b0};
    tabela[5]  = '{5'b00000, 3'd4, 1'b0, 1'b0};
    tabela[6]  = '{5'b01110, 3'd4, 1'b0, 1'b1};
    tabela[7]  = '{5'b10110, 3'd3, 1'b0, 1'b1};
    tabela[8]  = '{5'b11101, 3'd1, 1'b0, 1'b1};
    tabela[9]  = '{5'b01111, 3'd4, 1'b0, 1'b1};
    tabela[10] = '{5'b11011, 3'd2, 1'b0, 1'b1};

    sensores_in = 5'b11111;
    ack_in = 1'b0;
    rst_n = 1'b0;
    tick(2);
    chk("rst_estado", estado_out, 2'd0);
    chk("rst_bomba", bomba_out, 1'b0);
    chk("rst_alarme", alarme_out, 1'b0);
    chk("rst_filt", sensores_filt_out, 5'b11111);
    chk("rst_nivel", nivel_out, 3'd0);
    chk("rst_vazio", vazio_out, 1'b1);
    chk("rst_erro", erro_sensor_out, 1'b0);
    rst_n = 1'b1;

    // Level decode table: 1 input register + 4 samples + 1 decode register.
    for (int i = 0; i < 11; i++) begin
      sensores_in = tabela[i].pat;
      sb_q.push_back(tabela[i]);
      tick(7);
      e = sb_q.pop_front();
      chk($sformatf("tab%0d_filt", i), sensores_filt_out, e.pat);
      chk($sformatf("tab%0d_nivel", i), nivel_out, e.nivel);
      chk($sformatf("tab%0d_vazio", i), vazio_out, e.vazio);
      chk($sformatf("tab%0d_erro", i), erro_sensor_out, e.erro);
    end
    chk("sb_empty", sb_q.size(), 0);

    // Start filling from reset with 11110 held.
    sensores_in = 5'b11110;
    do_reset();
    tick();
    chk("start_estado", estado_out, 2'd1);
    chk("start_bomba", bomba_out, 1'b1);
    tick(3);
    chk("deb_not_yet", sensores_filt_out, 5'b11111);
    tick();
    chk("deb_accept", sensores_filt_out, 5'b11110);
    tick();
    chk("start_nivel", nivel_out, 3'd0);
    chk("start_vazio", vazio_out, 1'b0);

    // Toggle every 2 cycles never completes a debounce run.
    for (int i = 0; i < 8; i++) begin
      sensores_in = i[0] ? 5'b11110 : 5'b11100;
      tick(2);
    end
    chk("toggle_filt", sensores_filt_out, 5'b11110);
    chk("toggle_nivel", nivel_out, 3'd0);

    sensores_in = 5'b11100; tick(10); chk("fill_n1", nivel_out, 3'd1);
    sensores_in = 5'b11000; tick(10); chk("fill_n2", nivel_out, 3'd2);
    sensores_in = 5'b10000; tick(10); chk("fill_n3", nivel_out, 3'd3);
    chk("fill_bomba", bomba_out, 1'b1);
    sensores_in = 5'b00000;
    tick(6);
    chk("full_n4", nivel_out, 3'd4);
    chk("full_still_fill", estado_out, 2'd1);
    tick();
    chk("holdoff_estado", estado_out, 2'd2);
    chk("holdoff_bomba", bomba_out, 1'b0);
    n = 0;
    while (estado_out == 2'd2 && n < 20) begin
      n++;
      tick();
    end
    chk("holdoff_len", n, 8);
    chk("after_holdoff", estado_out, 2'd0);
    tick(3);
    chk("idle_full_stays", estado_out, 2'd0);

    // Inconsistent pattern during FILLING beats the simultaneous full level.
    sensores_in = 5'b11110;
    wait_state(2'd1, 20, "refill");
    sensores_in = 5'b01110;
    tick(6);
    chk("err_flag", erro_sensor_out, 1'b1);
    chk("err_nivel", nivel_out, 3'd4);
    tick();
    chk("err_fault", estado_out, 2'd3);
    chk("err_alarme", alarme_out, 1'b1);
    chk("err_bomba", bomba_out, 1'b0);
    ack_in = 1'b1;
    tick(10);
    chk("ack_bad_stays", estado_out, 2'd3);
    sensores_in = 5'b00000;
    wait_state(2'd2, 20, "ack_to_holdoff");
    chk("ack_alarme_off", alarme_out, 1'b0);
    ack_in = 1'b0;
    wait_state(2'd0, 20, "ack_to_idle");

    // Stalled level: FILLING visible for FILL_TIMEOUT+1 cycles, then FAULT.
    sensores_in = 5'b11110;
    wait_state(2'd1, 20, "to_fill_timeout");
    n = 0;
    while (estado_out == 2'd1 && n < 200) begin
      n++;
      tick();
    end
    chk("timeout_len", n, 65);
    chk("timeout_fault", estado_out, 2'd3);
    chk("timeout_alarme", alarme_out, 1'b1);
    chk("timeout_bomba", bomba_out, 1'b0);

    // One-cycle reset mid-FILLING.
    ack_in = 1'b1;
    wait_state(2'd1, 40, "to_fill_reset");
    ack_in = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_estado", estado_out, 2'd0);
    chk("mid_rst_bomba", bomba_out, 1'b0);
    chk("mid_rst_alarme", alarme_out, 1'b0);
    chk("mid_rst_filt", sensores_filt_out, 5'b11111);
    chk("mid_rst_nivel", nivel_out, 3'd0);
    chk("mid_rst_vazio", vazio_out, 1'b1);
    chk("mid_rst_erro", erro_sensor_out, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_holdoff", estado_out, 2'd1);
    chk("post_rst_bomba", bomba_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_bomba.md
CONTROLADOR_BOMBA -- requirements
Module: controlador_bomba

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, default 4, consecutive identical samples needed to accept a new sensor pattern; MIN_OFF_CYCLES, default 8, minimum pump-off time before restart; FILL_TIMEOUT, default 64, maximum FILLING cycles without level increase.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  input  1  single system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- sensores_in  input  5  raw level sensors, inverted logic (0 = water present); [0]=0%, [1]=25%, [2]=50%, [3]=75%, [4]=100%
- ack_in  input  1  operator fault acknowledge, level-sensitive
- sensores_filt_out  output  5  debounced pattern, same encoding, drives the display decoder
- nivel_out  output  3  level 0..4 = index of highest wet bit of sensores_filt_out; 0 when no bit is wet
- vazio_out  output  1  1 when sensores_filt_out = 5'b11111
- erro_sensor_out  output  1  1 when sensores_filt_out is inconsistent
- bomba_out  output  1  pump enable
- alarme_out  output  1  1 while in FAULT
- estado_out  output  2  IDLE=0, FILLING=1, HOLDOFF=2, FAULT=3

Function
REQ-003 Debounce SHALL register sensores_in once per cycle; sensores_filt_out SHALL take a new value only after DEBOUNCE_CYCLES consecutive identical registered samples differ from it; any mismatch restarts the count.
REQ-004 nivel_out, vazio_out and erro_sensor_out SHALL be registered, updating one cycle after sensores_filt_out.
REQ-005 A pattern SHALL be consistent iff its wet bits are contiguous from bit 0 (11111, 11110, 11100, 11000, 10000, 00000); all others SHALL set erro_sensor_out.
REQ-006 When inconsistent, nivel_out SHALL still report the highest wet bit (100% has priority).
REQ-007 IDLE -> FILLING when nivel_out <= 1 and erro_sensor_out = 0; bomba_out asserts in the cycle estado_out first shows FILLING.
REQ-008 FILLING -> HOLDOFF when nivel_out = 4; bomba_out deasserts with the transition.
REQ-009 FILLING -> FAULT when erro_sensor_out = 1, or when a timeout counter reaches FILL_TIMEOUT; the counter clears on entry to FILLING and whenever nivel_out increases.
REQ-010 HOLDOFF SHALL count MIN_OFF_CYCLES cycles, then go to IDLE; erro_sensor_out = 1 in HOLDOFF SHALL go to FAULT immediately.
REQ-011 FAULT SHALL hold bomba_out = 0 and alarme_out = 1, exiting to HOLDOFF (counter cleared) only when ack_in = 1 and erro_sensor_out = 0.
REQ-012 erro_sensor_out = 1 in IDLE SHALL go to FAULT.
REQ-013 The timeout and holdoff counters SHALL saturate and never wrap; widths derived from parameters via clog2.
REQ-014 Simultaneous conditions in FILLING SHALL be prioritised: erro_sensor_out, then nivel_out = 4, then timeout.
REQ-015 bomba_out SHALL be 1 only in FILLING and SHALL be a registered output.

Reset
REQ-016 While rst_n = 0 at a rising edge: estado_out = IDLE; bomba_out = 0; alarme_out = 0; sensores_filt_out = 5'b11111; nivel_out = 0; vazio_out = 1; erro_sensor_out = 0; all counters = 0.
REQ-017 Reset asserted mid-FILLING SHALL drop bomba_out at that same edge, with no holdoff afterwards.

Verification
REQ-018 Bench SHALL cover:
- Reset, sensores_in = 5'b11110 held -> sensores_filt_out = 11110 after 4 stable cycles, nivel_out = 0, pump on, estado_out = 1.
- Filling sequence 11100 -> 11000 -> 10000 -> 00000, each held 10 cycles -> nivel_out steps 1 to 4; at 4 bomba_out = 0 and estado_out = 2 for 8 cycles, then 0.
- sensores_in toggling 11110/11100 every 2 cycles -> sensores_filt_out unchanged.
- 5'b01110 stable during FILLING -> erro_sensor_out = 1, nivel_out = 4, FAULT; ack_in = 1 with 01110 -> stays FAULT; 00000 + ack_in -> HOLDOFF.
- Level stuck at 11110 for 64 FILLING cycles -> FAULT, alarme_out = 1, bomba_out = 0.
- rst_n = 0 for one cycle mid-FILLING -> all outputs at reset values next cycle.
